// File: rtl/ysyx_22050612_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: controller states, owner
// encoding and default bus widths.
package ysyx_22050612_arb_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_22050612_arb_sel.sv
// Combinational grant selection between the fetch and load/store requesters.
// On a conflict the requester that was not granted last wins.
module ysyx_22050612_arb_sel
  import ysyx_22050612_arb_pkg::*;
(
  input  logic   ifu_valid,
  input  logic   lsu_valid,
  input  owner_e last_grant,
  output logic   grant_valid,
  output owner_e grant
);

  always_comb begin
    grant_valid = ifu_valid | lsu_valid;
    grant       = OWN_IFU;
    if (ifu_valid && lsu_valid) begin
      grant = (last_grant == OWN_LSU) ? OWN_IFU : OWN_LSU;
    end else if (lsu_valid) begin
      grant = OWN_LSU;
    end
  end

endmodule

// File: rtl/ysyx_22050612_mem_arb.sv
// Single-outstanding memory arbiter for IFU and LSU. Fixed LSU priority by
// default; define YSYX_22050612_ARB_RR_EN for round-robin arbitration.
module ysyx_22050612_mem_arb
  import ysyx_22050612_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_wen,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
  logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
  logic                ifu_resp_q, ifu_resp_d;
  logic                lsu_resp_q, lsu_resp_d;
  logic                grant_valid;
  owner_e              grant;
  owner_e              last_grant;

`ifdef YSYX_22050612_ARB_RR_EN
  owner_e ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && grant_valid) ptr_d = grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= OWN_IFU;
    else        ptr_q <= ptr_d;
  end

  assign last_grant = ptr_q;
`else
  // Pretending IFU was always granted last makes the selector favour LSU.
  assign last_grant = OWN_IFU;
`endif

  ysyx_22050612_arb_sel u_sel (
    .ifu_valid   (ifu_req_valid),
    .lsu_valid   (lsu_req_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    wen_d         = wen_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    ifu_rdata_d   = ifu_rdata_q;
    lsu_rdata_d   = lsu_rdata_q;
    ifu_resp_d    = 1'b0;
    lsu_resp_d    = 1'b0;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant;
          state_d = ISSUE;
          if (grant == OWN_LSU) begin
            lsu_req_ready = 1'b1;
            wen_d         = lsu_wen;
            addr_d        = lsu_addr;
            wdata_d       = lsu_wdata;
            wmask_d       = lsu_wmask;
          end else begin
            ifu_req_ready = 1'b1;
            wen_d         = 1'b0;
            addr_d        = ifu_addr;
            wdata_d       = '0;
            wmask_d       = '0;
          end
        end
      end
      ISSUE: begin
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          state_d = IDLE;
          if (owner_q == OWN_LSU) begin
            lsu_rdata_d = mem_rdata;
            lsu_resp_d  = 1'b1;
          end else begin
            ifu_rdata_d = mem_rdata;
            ifu_resp_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IFU;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
      ifu_resp_q  <= ifu_resp_d;
      lsu_resp_q  <= lsu_resp_d;
    end
  end

  assign mem_req_valid  = (state_q == ISSUE);
  assign mem_wen        = wen_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign ifu_resp_valid = ifu_resp_q;
  assign ifu_rdata      = ifu_rdata_q;
  assign lsu_resp_valid = lsu_resp_q;
  assign lsu_rdata      = lsu_rdata_q;

endmodule
